// File: rtl/ann_loss_scheduler_pkg.sv
// Shared definitions for the loss scheduler: FSM state encoding and default sizing constants.
package ann_loss_scheduler_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StIssue  = 3'd2,
        StWait   = 3'd3,
        StWrite  = 3'd4,
        StFinish = 3'd5,
        StError  = 3'd6
    } state_e;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefBatchSize = 8;
    localparam int unsigned DefIdxWidth  = 3;
    localparam int unsigned DefTimeout   = 32;

    function automatic logic state_is_busy(input state_e s);
        return (s == StFetch) || (s == StIssue) || (s == StWait) ||
               (s == StWrite) || (s == StFinish);
    endfunction

endpackage

// File: rtl/ann_loss_scheduler.sv
// Sequences a batch of transitions through an external loss unit one at a time and writes
// each returned target value into the target buffer at the transition's batch index.
module ann_loss_scheduler
    import ann_loss_scheduler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned BATCH_SIZE = DefBatchSize,
    parameter int unsigned IDX_WIDTH  = DefIdxWidth,
    parameter int unsigned TIMEOUT    = DefTimeout
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_trans_valid,
    output logic                  o_trans_ready,
    input  logic [DATA_WIDTH-1:0] i_reward,
    input  logic                  i_done,
    input  logic [DATA_WIDTH-1:0] i_q_max,
    output logic                  o_q_max_valid,
    output logic [DATA_WIDTH-1:0] o_q_max,
    output logic                  o_reward_valid,
    output logic [DATA_WIDTH-1:0] o_reward,
    output logic                  o_done,
    input  logic                  i_loss_value_valid,
    input  logic [DATA_WIDTH-1:0] i_loss_value,
    output logic                  o_tgt_wr_en,
    output logic [IDX_WIDTH-1:0]  o_tgt_wr_addr,
    output logic [DATA_WIDTH-1:0] o_tgt_wr_data,
    output logic                  o_busy,
    output logic                  o_batch_done,
    output logic                  o_error
);

    localparam int unsigned CntWidth = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntWidth-1:0]  CntLast = CntWidth'(TIMEOUT - 1);
    localparam logic [IDX_WIDTH-1:0] IdxLast = IDX_WIDTH'(BATCH_SIZE - 1);

    state_e                state_q, state_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] reward_q, reward_d;
    logic [DATA_WIDTH-1:0] q_max_q, q_max_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] loss_q, loss_d;

    logic handshake;

    assign handshake = (state_q == StFetch) && i_trans_valid;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q    <= '0;
            cnt_q    <= '0;
            reward_q <= '0;
            q_max_q  <= '0;
            done_q   <= 1'b0;
            loss_q   <= '0;
        end else begin
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            reward_q <= reward_d;
            q_max_q  <= q_max_d;
            done_q   <= done_d;
            loss_q   <= loss_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (handshake) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                // A result arriving on the last allowed cycle still counts.
                if (i_loss_value_valid) begin
                    state_d = StWrite;
                end else if (cnt_q == CntLast) begin
                    state_d = StError;
                end
            end
            StWrite: begin
                state_d = (idx_q == IdxLast) ? StFinish : StFetch;
            end
            StFinish: begin
                state_d = StIdle;
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        reward_d = reward_q;
        q_max_d  = q_max_q;
        done_d   = done_q;
        loss_d   = loss_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    idx_d = '0;
                end
            end
            StFetch: begin
                if (handshake) begin
                    reward_d = i_reward;
                    q_max_d  = i_q_max;
                    done_d   = i_done;
                end
            end
            StIssue: begin
                cnt_d = '0;
            end
            StWait: begin
                if (i_loss_value_valid) begin
                    loss_d = i_loss_value;
                end else if (cnt_q != CntLast) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWrite: begin
                if (idx_q != IdxLast) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Output logic: data buses are gated so they read zero outside their strobe cycles.
    always_comb begin
        o_trans_ready  = 1'b0;
        o_q_max_valid  = 1'b0;
        o_reward_valid = 1'b0;
        o_q_max        = '0;
        o_reward       = '0;
        o_done         = 1'b0;
        o_tgt_wr_en    = 1'b0;
        o_tgt_wr_addr  = '0;
        o_tgt_wr_data  = '0;
        o_batch_done   = 1'b0;
        o_error        = 1'b0;
        o_busy         = state_is_busy(state_q);
        unique case (state_q)
            StFetch: begin
                o_trans_ready = i_trans_valid;
            end
            StIssue: begin
                o_q_max_valid  = 1'b1;
                o_reward_valid = 1'b1;
                o_q_max        = q_max_q;
                o_reward       = reward_q;
                o_done         = done_q;
            end
            StWrite: begin
                o_tgt_wr_en   = 1'b1;
                o_tgt_wr_addr = idx_q;
                o_tgt_wr_data = loss_q;
            end
            StFinish: begin
                o_batch_done = 1'b1;
            end
            StError: begin
                o_error = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/ann_loss_scheduler.md
ANN_LOSS_SCHEDULER -- requirements
Module: ann_loss_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 32, float word width.
REQ-002 Parameter BATCH_SIZE, default 8, transitions per batch (power of two, >=2).
REQ-003 Parameter IDX_WIDTH, default 3, log2(BATCH_SIZE).
REQ-004 Parameter TIMEOUT, default 32, maximum cycles waiting for one loss result.
REQ-005 Port list, one per line:
 clk  in  1  clock, single clock domain
 rst_n  in  1  reset, synchronous, active-low
 i_start  in  1  one-cycle pulse, begin batch
 i_trans_valid  in  1  transition present
 o_trans_ready  out  1  transition consumed this cycle
 i_reward  in  DATA_WIDTH  transition reward
 i_done  in  1  terminal-state flag
 i_q_max  in  DATA_WIDTH  next-state Q max
 o_q_max_valid  out  1  issue pulse to loss unit
 o_q_max  out  DATA_WIDTH  Q max to loss unit
 o_reward_valid  out  1  issue pulse to loss unit
 o_reward  out  DATA_WIDTH  reward to loss unit
 o_done  out  1  done flag to loss unit
 i_loss_value_valid  in  1  loss unit result strobe
 i_loss_value  in  DATA_WIDTH  loss unit target value
 o_tgt_wr_en  out  1  target buffer write strobe
 o_tgt_wr_addr  out  IDX_WIDTH  target buffer index
 o_tgt_wr_data  out  DATA_WIDTH  target value
 o_busy  out  1  batch in progress
 o_batch_done  out  1  one-cycle pulse, batch complete
 o_error  out  1  sticky timeout flag

Function
REQ-006 FSM states: IDLE, FETCH, ISSUE, WAIT, WRITE, FINISH, ERROR.
REQ-007 IDLE: i_start=1 -> FETCH, index cleared to 0; i_start ignored in all other states.
REQ-008 FETCH: o_trans_ready=1 combinationally when i_trans_valid=1; on handshake latch i_reward, i_done, i_q_max -> ISSUE.
REQ-009 ISSUE: single cycle, o_q_max_valid=o_reward_valid=1 together with latched operands -> WAIT, timeout counter cleared.
REQ-010 Exactly one transition in flight at any time; no issue while in WAIT or WRITE.
REQ-011 WAIT: i_loss_value_valid=1 -> capture i_loss_value, go WRITE; else increment counter; counter reaching TIMEOUT-1 without result -> ERROR.
REQ-012 i_loss_value_valid outside WAIT is ignored (no write, no state change).
REQ-013 WRITE: o_tgt_wr_en=1 for one cycle, o_tgt_wr_addr=index, o_tgt_wr_data=captured value; index=BATCH_SIZE-1 -> FINISH, else index+1 and FETCH.
REQ-014 FINISH: o_batch_done=1 for one cycle -> IDLE.
REQ-015 ERROR: o_error=1 held; remains until reset; o_busy=0.
REQ-016 o_busy=1 in FETCH, ISSUE, WAIT, WRITE, FINISH.
REQ-017 Per-transition latency ISSUE->WRITE = loss unit latency + 1 cycle capture; handshake in FETCH costs >=1 cycle.
REQ-018 Index counter IDX_WIDTH bits, no wrap inside a batch; timeout counter width clog2(TIMEOUT).
REQ-019 Result strobe arriving in the same cycle the counter hits TIMEOUT-1: result wins, go WRITE.

Reset
REQ-020 rst_n=0 sampled at clk edge: state IDLE, index 0, counter 0, all outputs 0, latched operands 0.
REQ-021 Reset mid-batch abandons batch silently: no o_batch_done, no further writes; o_error cleared.

Structure
REQ-022 Shared package holds FSM state encoding and default DATA_WIDTH/BATCH_SIZE/TIMEOUT constants.
REQ-023 Single flat module; no sub-modules; loss unit instantiated by parent, not inside.

Verification
REQ-024 Start, transition reward=0x3F800000, q_max=0x3F800000, done=0, model returns 0x3FE66666 after 15 cycles -> write addr 0 data 0x3FE66666.
REQ-025 Full batch of 8 with i_trans_valid always high -> 8 writes, addresses 0..7 in order, one o_batch_done, o_busy low after.
REQ-026 i_trans_valid deasserted 5 cycles mid-batch -> scheduler holds in FETCH, no issue pulse, batch completes correctly.
REQ-027 Loss model never responds -> o_error=1 after TIMEOUT cycles in WAIT, no write, i_start then ignored.
REQ-028 Stray i_loss_value_valid during FETCH and reset asserted in WAIT -> no write, outputs 0, IDLE next cycle.
REQ-029 done=1 transition -> o_done=1 on issue cycle, write data equals returned value unchanged.
